// File: rtl/diff_commit_packer.sv
// Difftest commit producer: compacts up to four ROB retirements into ordered,
// registered commit slots and keeps a shadow GPR file, retire counter and hang watchdog.
module diff_commit_packer #(
  parameter int TIMEOUT = 10000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid_0, in_valid_1, in_valid_2, in_valid_3,
  input  logic [31:0] in_pc_0, in_pc_1, in_pc_2, in_pc_3,
  input  logic [31:0] in_instr_0, in_instr_1, in_instr_2, in_instr_3,
  input  logic        in_skip_0, in_skip_1, in_skip_2, in_skip_3,
  input  logic        in_is_tlbfill_0, in_is_tlbfill_1, in_is_tlbfill_2, in_is_tlbfill_3,
  input  logic [4:0]  in_tlbfill_index_0, in_tlbfill_index_1, in_tlbfill_index_2, in_tlbfill_index_3,
  input  logic        in_is_cnt_0, in_is_cnt_1, in_is_cnt_2, in_is_cnt_3,
  input  logic        in_wen_0, in_wen_1, in_wen_2, in_wen_3,
  input  logic [4:0]  in_wdest_0, in_wdest_1, in_wdest_2, in_wdest_3,
  input  logic [31:0] in_wdata_0, in_wdata_1, in_wdata_2, in_wdata_3,
  input  logic        in_csr_rstat_0, in_csr_rstat_1, in_csr_rstat_2, in_csr_rstat_3,
  input  logic [31:0] in_csr_data_0, in_csr_data_1, in_csr_data_2, in_csr_data_3,
  input  logic [63:0] timer_64,
  output logic        Instrvalid_0, Instrvalid_1, Instrvalid_2, Instrvalid_3,
  output logic [7:0]  index_0, index_1, index_2, index_3,
  output logic [63:0] the_pc_0, the_pc_1, the_pc_2, the_pc_3,
  output logic [31:0] instr_0, instr_1, instr_2, instr_3,
  output logic        skip_0, skip_1, skip_2, skip_3,
  output logic        is_TLBFILL_0, is_TLBFILL_1, is_TLBFILL_2, is_TLBFILL_3,
  output logic [4:0]  TLBFILL_index_0, TLBFILL_index_1, TLBFILL_index_2, TLBFILL_index_3,
  output logic        is_CNTinst_0, is_CNTinst_1, is_CNTinst_2, is_CNTinst_3,
  output logic        csr_rstat_0, csr_rstat_1, csr_rstat_2, csr_rstat_3,
  output logic [31:0] csr_data_0, csr_data_1, csr_data_2, csr_data_3,
  output logic [63:0] timer_64_value_0, timer_64_value_1, timer_64_value_2, timer_64_value_3,
  output logic        wen_0, wen_1, wen_2, wen_3,
  output logic [7:0]  wdest_0, wdest_1, wdest_2, wdest_3,
  output logic [63:0] wdata_0, wdata_1, wdata_2, wdata_3,
  output logic [63:0] REG_0, REG_1, REG_2, REG_3, REG_4, REG_5, REG_6, REG_7,
  output logic [63:0] REG_8, REG_9, REG_10, REG_11, REG_12, REG_13, REG_14, REG_15,
  output logic [63:0] REG_16, REG_17, REG_18, REG_19, REG_20, REG_21, REG_22, REG_23,
  output logic [63:0] REG_24, REG_25, REG_26, REG_27, REG_28, REG_29, REG_30, REG_31,
  output logic [63:0] commit_count,
  output logic        hang
);
  localparam int IW = $clog2(TIMEOUT + 1);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        skip;
    logic        tlbfill;
    logic [4:0]  tlb_idx;
    logic        cnt;
    logic        wen;
    logic [4:0]  wdest;
    logic [31:0] wdata;
    logic        rstat;
    logic [31:0] csr;
  } lane_t;

  typedef struct packed {
    logic        valid;
    lane_t       ln;
    logic [63:0] timer;
  } slot_t;

  lane_t       lane [4];
  logic [3:0]  vld;
  slot_t       slot_d [4], slot_q [4];
  logic [2:0]  n;
  logic [31:0] gpr_d [32], gpr_q [32];
  logic [63:0] cnt_q;
  logic [IW-1:0] idle_d, idle_q;
  logic        hang_d, hang_q;

  assign vld = {in_valid_3, in_valid_2, in_valid_1, in_valid_0};
  assign lane[0] = '{pc: in_pc_0, instr: in_instr_0, skip: in_skip_0, tlbfill: in_is_tlbfill_0,
                     tlb_idx: in_tlbfill_index_0, cnt: in_is_cnt_0, wen: in_wen_0, wdest: in_wdest_0,
                     wdata: in_wdata_0, rstat: in_csr_rstat_0, csr: in_csr_data_0};
  assign lane[1] = '{pc: in_pc_1, instr: in_instr_1, skip: in_skip_1, tlbfill: in_is_tlbfill_1,
                     tlb_idx: in_tlbfill_index_1, cnt: in_is_cnt_1, wen: in_wen_1, wdest: in_wdest_1,
                     wdata: in_wdata_1, rstat: in_csr_rstat_1, csr: in_csr_data_1};
  assign lane[2] = '{pc: in_pc_2, instr: in_instr_2, skip: in_skip_2, tlbfill: in_is_tlbfill_2,
                     tlb_idx: in_tlbfill_index_2, cnt: in_is_cnt_2, wen: in_wen_2, wdest: in_wdest_2,
                     wdata: in_wdata_2, rstat: in_csr_rstat_2, csr: in_csr_data_2};
  assign lane[3] = '{pc: in_pc_3, instr: in_instr_3, skip: in_skip_3, tlbfill: in_is_tlbfill_3,
                     tlb_idx: in_tlbfill_index_3, cnt: in_is_cnt_3, wen: in_wen_3, wdest: in_wdest_3,
                     wdata: in_wdata_3, rstat: in_csr_rstat_3, csr: in_csr_data_3};

  // Running count of valid lanes gives each lane its slot; empty slots stay all-zero.
  always_comb begin
    n = '0;
    for (int s = 0; s < 4; s++) slot_d[s] = '0;
    for (int k = 0; k < 4; k++) begin
      if (vld[k]) begin
        slot_d[n[1:0]].valid  = 1'b1;
        slot_d[n[1:0]].ln     = lane[k];
        slot_d[n[1:0]].ln.wen = lane[k].wen && (lane[k].wdest != 5'd0);
        slot_d[n[1:0]].timer  = timer_64;
        n = n + 3'd1;
      end
    end
  end

  // Ascending lane order so the youngest writer of a shared destination wins.
  always_comb begin
    gpr_d = gpr_q;
    for (int k = 0; k < 4; k++)
      if (vld[k] && lane[k].wen && (lane[k].wdest != 5'd0))
        gpr_d[lane[k].wdest] = lane[k].wdata;
  end

  always_comb begin
    idle_d = idle_q;
    if (n != 3'd0)                idle_d = '0;
    else if (idle_q != IW'(TIMEOUT)) idle_d = idle_q + 1'b1;
    hang_d = hang_q | (idle_d == IW'(TIMEOUT));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < 4; s++)  slot_q[s] <= '0;
      for (int r = 0; r < 32; r++) gpr_q[r]  <= '0;
      cnt_q  <= '0;
      idle_q <= '0;
      hang_q <= 1'b0;
    end else begin
      slot_q <= slot_d;
      gpr_q  <= gpr_d;
      cnt_q  <= cnt_q + 64'(n);
      idle_q <= idle_d;
      hang_q <= hang_d;
    end
  end

  assign commit_count = cnt_q;
  assign hang         = hang_q;

  assign Instrvalid_0 = slot_q[0].valid;  assign Instrvalid_1 = slot_q[1].valid;
  assign Instrvalid_2 = slot_q[2].valid;  assign Instrvalid_3 = slot_q[3].valid;
  assign index_0 = 8'd0;
  assign index_1 = slot_q[1].valid ? 8'd1 : 8'd0;
  assign index_2 = slot_q[2].valid ? 8'd2 : 8'd0;
  assign index_3 = slot_q[3].valid ? 8'd3 : 8'd0;
  assign the_pc_0 = {32'd0, slot_q[0].ln.pc};  assign the_pc_1 = {32'd0, slot_q[1].ln.pc};
  assign the_pc_2 = {32'd0, slot_q[2].ln.pc};  assign the_pc_3 = {32'd0, slot_q[3].ln.pc};
  assign instr_0 = slot_q[0].ln.instr;  assign instr_1 = slot_q[1].ln.instr;
  assign instr_2 = slot_q[2].ln.instr;  assign instr_3 = slot_q[3].ln.instr;
  assign skip_0 = slot_q[0].ln.skip;  assign skip_1 = slot_q[1].ln.skip;
  assign skip_2 = slot_q[2].ln.skip;  assign skip_3 = slot_q[3].ln.skip;
  assign is_TLBFILL_0 = slot_q[0].ln.tlbfill;  assign is_TLBFILL_1 = slot_q[1].ln.tlbfill;
  assign is_TLBFILL_2 = slot_q[2].ln.tlbfill;  assign is_TLBFILL_3 = slot_q[3].ln.tlbfill;
  assign TLBFILL_index_0 = slot_q[0].ln.tlb_idx;  assign TLBFILL_index_1 = slot_q[1].ln.tlb_idx;
  assign TLBFILL_index_2 = slot_q[2].ln.tlb_idx;  assign TLBFILL_index_3 = slot_q[3].ln.tlb_idx;
  assign is_CNTinst_0 = slot_q[0].ln.cnt;  assign is_CNTinst_1 = slot_q[1].ln.cnt;
  assign is_CNTinst_2 = slot_q[2].ln.cnt;  assign is_CNTinst_3 = slot_q[3].ln.cnt;
  assign csr_rstat_0 = slot_q[0].ln.rstat;  assign csr_rstat_1 = slot_q[1].ln.rstat;
  assign csr_rstat_2 = slot_q[2].ln.rstat;  assign csr_rstat_3 = slot_q[3].ln.rstat;
  assign csr_data_0 = slot_q[0].ln.csr;  assign csr_data_1 = slot_q[1].ln.csr;
  assign csr_data_2 = slot_q[2].ln.csr;  assign csr_data_3 = slot_q[3].ln.csr;
  assign timer_64_value_0 = slot_q[0].timer;  assign timer_64_value_1 = slot_q[1].timer;
  assign timer_64_value_2 = slot_q[2].timer;  assign timer_64_value_3 = slot_q[3].timer;
  assign wen_0 = slot_q[0].ln.wen;  assign wen_1 = slot_q[1].ln.wen;
  assign wen_2 = slot_q[2].ln.wen;  assign wen_3 = slot_q[3].ln.wen;
  assign wdest_0 = {3'd0, slot_q[0].ln.wdest};  assign wdest_1 = {3'd0, slot_q[1].ln.wdest};
  assign wdest_2 = {3'd0, slot_q[2].ln.wdest};  assign wdest_3 = {3'd0, slot_q[3].ln.wdest};
  assign wdata_0 = {32'd0, slot_q[0].ln.wdata};  assign wdata_1 = {32'd0, slot_q[1].ln.wdata};
  assign wdata_2 = {32'd0, slot_q[2].ln.wdata};  assign wdata_3 = {32'd0, slot_q[3].ln.wdata};

  assign REG_0  = {32'd0, gpr_q[0]};   assign REG_1  = {32'd0, gpr_q[1]};
  assign REG_2  = {32'd0, gpr_q[2]};   assign REG_3  = {32'd0, gpr_q[3]};
  assign REG_4  = {32'd0, gpr_q[4]};   assign REG_5  = {32'd0, gpr_q[5]};
  assign REG_6  = {32'd0, gpr_q[6]};   assign REG_7  = {32'd0, gpr_q[7]};
  assign REG_8  = {32'd0, gpr_q[8]};   assign REG_9  = {32'd0, gpr_q[9]};
  assign REG_10 = {32'd0, gpr_q[10]};  assign REG_11 = {32'd0, gpr_q[11]};
  assign REG_12 = {32'd0, gpr_q[12]};  assign REG_13 = {32'd0, gpr_q[13]};
  assign REG_14 = {32'd0, gpr_q[14]};  assign REG_15 = {32'd0, gpr_q[15]};
  assign REG_16 = {32'd0, gpr_q[16]};  assign REG_17 = {32'd0, gpr_q[17]};
  assign REG_18 = {32'd0, gpr_q[18]};  assign REG_19 = {32'd0, gpr_q[19]};
  assign REG_20 = {32'd0, gpr_q[20]};  assign REG_21 = {32'd0, gpr_q[21]};
  assign REG_22 = {32'd0, gpr_q[22]};  assign REG_23 = {32'd0, gpr_q[23]};
  assign REG_24 = {32'd0, gpr_q[24]};  assign REG_25 = {32'd0, gpr_q[25]};
  assign REG_26 = {32'd0, gpr_q[26]};  assign REG_27 = {32'd0, gpr_q[27]};
  assign REG_28 = {32'd0, gpr_q[28]};  assign REG_29 = {32'd0, gpr_q[29]};
  assign REG_30 = {32'd0, gpr_q[30]};  assign REG_31 = {32'd0, gpr_q[31]};
endmodule

// File: tb/tb_diff_commit_packer.sv
// Bench for diff_commit_packer: directed scenarios plus random bundles checked
// against a queue-based reference model of compaction, shadow GPRs and watchdog.
module tb_diff_commit_packer;
  localparam int T = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        in_valid [4], in_skip [4], in_tlb [4], in_cnt [4], in_wen [4], in_rstat [4];
  logic [31:0] in_pc [4], in_instr [4], in_wdata [4], in_csr [4];
  logic [4:0]  in_tidx [4], in_wdest [4];
  logic [63:0] timer;

  logic        o_v [4], o_skip [4], o_tlb [4], o_cnt [4], o_rstat [4], o_wen [4];
  logic [7:0]  o_idx [4], o_wdest [4];
  logic [63:0] o_pc [4], o_timer [4], o_wdata [4];
  logic [31:0] o_instr [4], o_csr [4];
  logic [4:0]  o_tidx [4];
  logic [63:0] REG [32];
  logic [63:0] cc;
  logic        hang;

  diff_commit_packer #(.TIMEOUT(T)) dut (
    .clock(clock), .reset(reset),
    .in_valid_0(in_valid[0]), .in_valid_1(in_valid[1]), .in_valid_2(in_valid[2]), .in_valid_3(in_valid[3]),
    .in_pc_0(in_pc[0]), .in_pc_1(in_pc[1]), .in_pc_2(in_pc[2]), .in_pc_3(in_pc[3]),
    .in_instr_0(in_instr[0]), .in_instr_1(in_instr[1]), .in_instr_2(in_instr[2]), .in_instr_3(in_instr[3]),
    .in_skip_0(in_skip[0]), .in_skip_1(in_skip[1]), .in_skip_2(in_skip[2]), .in_skip_3(in_skip[3]),
    .in_is_tlbfill_0(in_tlb[0]), .in_is_tlbfill_1(in_tlb[1]), .in_is_tlbfill_2(in_tlb[2]), .in_is_tlbfill_3(in_tlb[3]),
    .in_tlbfill_index_0(in_tidx[0]), .in_tlbfill_index_1(in_tidx[1]),
    .in_tlbfill_index_2(in_tidx[2]), .in_tlbfill_index_3(in_tidx[3]),
    .in_is_cnt_0(in_cnt[0]), .in_is_cnt_1(in_cnt[1]), .in_is_cnt_2(in_cnt[2]), .in_is_cnt_3(in_cnt[3]),
    .in_wen_0(in_wen[0]), .in_wen_1(in_wen[1]), .in_wen_2(in_wen[2]), .in_wen_3(in_wen[3]),
    .in_wdest_0(in_wdest[0]), .in_wdest_1(in_wdest[1]), .in_wdest_2(in_wdest[2]), .in_wdest_3(in_wdest[3]),
    .in_wdata_0(in_wdata[0]), .in_wdata_1(in_wdata[1]), .in_wdata_2(in_wdata[2]), .in_wdata_3(in_wdata[3]),
    .in_csr_rstat_0(in_rstat[0]), .in_csr_rstat_1(in_rstat[1]), .in_csr_rstat_2(in_rstat[2]), .in_csr_rstat_3(in_rstat[3]),
    .in_csr_data_0(in_csr[0]), .in_csr_data_1(in_csr[1]), .in_csr_data_2(in_csr[2]), .in_csr_data_3(in_csr[3]),
    .timer_64(timer),
    .Instrvalid_0(o_v[0]), .Instrvalid_1(o_v[1]), .Instrvalid_2(o_v[2]), .Instrvalid_3(o_v[3]),
    .index_0(o_idx[0]), .index_1(o_idx[1]), .index_2(o_idx[2]), .index_3(o_idx[3]),
    .the_pc_0(o_pc[0]), .the_pc_1(o_pc[1]), .the_pc_2(o_pc[2]), .the_pc_3(o_pc[3]),
    .instr_0(o_instr[0]), .instr_1(o_instr[1]), .instr_2(o_instr[2]), .instr_3(o_instr[3]),
    .skip_0(o_skip[0]), .skip_1(o_skip[1]), .skip_2(o_skip[2]), .skip_3(o_skip[3]),
    .is_TLBFILL_0(o_tlb[0]), .is_TLBFILL_1(o_tlb[1]), .is_TLBFILL_2(o_tlb[2]), .is_TLBFILL_3(o_tlb[3]),
    .TLBFILL_index_0(o_tidx[0]), .TLBFILL_index_1(o_tidx[1]), .TLBFILL_index_2(o_tidx[2]), .TLBFILL_index_3(o_tidx[3]),
    .is_CNTinst_0(o_cnt[0]), .is_CNTinst_1(o_cnt[1]), .is_CNTinst_2(o_cnt[2]), .is_CNTinst_3(o_cnt[3]),
    .csr_rstat_0(o_rstat[0]), .csr_rstat_1(o_rstat[1]), .csr_rstat_2(o_rstat[2]), .csr_rstat_3(o_rstat[3]),
    .csr_data_0(o_csr[0]), .csr_data_1(o_csr[1]), .csr_data_2(o_csr[2]), .csr_data_3(o_csr[3]),
    .timer_64_value_0(o_timer[0]), .timer_64_value_1(o_timer[1]),
    .timer_64_value_2(o_timer[2]), .timer_64_value_3(o_timer[3]),
    .wen_0(o_wen[0]), .wen_1(o_wen[1]), .wen_2(o_wen[2]), .wen_3(o_wen[3]),
    .wdest_0(o_wdest[0]), .wdest_1(o_wdest[1]), .wdest_2(o_wdest[2]), .wdest_3(o_wdest[3]),
    .wdata_0(o_wdata[0]), .wdata_1(o_wdata[1]), .wdata_2(o_wdata[2]), .wdata_3(o_wdata[3]),
    .REG_0(REG[0]), .REG_1(REG[1]), .REG_2(REG[2]), .REG_3(REG[3]),
    .REG_4(REG[4]), .REG_5(REG[5]), .REG_6(REG[6]), .REG_7(REG[7]),
    .REG_8(REG[8]), .REG_9(REG[9]), .REG_10(REG[10]), .REG_11(REG[11]),
    .REG_12(REG[12]), .REG_13(REG[13]), .REG_14(REG[14]), .REG_15(REG[15]),
    .REG_16(REG[16]), .REG_17(REG[17]), .REG_18(REG[18]), .REG_19(REG[19]),
    .REG_20(REG[20]), .REG_21(REG[21]), .REG_22(REG[22]), .REG_23(REG[23]),
    .REG_24(REG[24]), .REG_25(REG[25]), .REG_26(REG[26]), .REG_27(REG[27]),
    .REG_28(REG[28]), .REG_29(REG[29]), .REG_30(REG[30]), .REG_31(REG[31]),
    .commit_count(cc), .hang(hang)
  );

  typedef struct {
    logic [63:0] v, idx, pc, instr, misc, csr, tmr, wdata;
  } exp_t;

  exp_t        ex [4];
  logic [63:0] mg [32];
  logic [63:0] mcc;
  int          midle;
  logic        mhang;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] misc(input logic skip, tlb, input logic [4:0] ti,
                                       input logic cnt, rstat, wen, input logic [7:0] wd);
    return {46'd0, skip, tlb, ti, cnt, rstat, wen, wd};
  endfunction

  task automatic rnd_lane(input int k, input logic v);
    in_valid[k] = v;
    in_pc[k]    = $urandom;
    in_instr[k] = $urandom;
    in_skip[k]  = 1'($urandom_range(0, 1));
    in_tlb[k]   = 1'($urandom_range(0, 1));
    in_tidx[k]  = 5'($urandom_range(0, 31));
    in_cnt[k]   = 1'($urandom_range(0, 1));
    in_wen[k]   = 1'($urandom_range(0, 1));
    in_wdest[k] = 5'($urandom_range(0, 7));
    in_wdata[k] = $urandom;
    in_rstat[k] = 1'($urandom_range(0, 1));
    in_csr[k]   = $urandom;
  endtask

  task automatic set_lane(input int k, input logic [31:0] pc, input logic wen,
                          input logic [4:0] wd, input logic [31:0] wdata);
    rnd_lane(k, 1'b1);
    in_pc[k] = pc; in_wen[k] = wen; in_wdest[k] = wd; in_wdata[k] = wdata;
  endtask

  task automatic idle_lanes();
    for (int k = 0; k < 4; k++) rnd_lane(k, 1'b0);
  endtask

  // One clock: predict from the presented inputs, advance, then compare everything.
  task automatic step(input logic rst);
    int q[$];
    int k;
    reset = rst;
    timer = {$urandom, $urandom};
    for (int s = 0; s < 4; s++) ex[s] = '{default: '0};
    if (rst) begin
      for (int r = 0; r < 32; r++) mg[r] = '0;
      mcc = '0; midle = 0; mhang = 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) if (in_valid[i]) q.push_back(i);
      foreach (q[s]) begin
        k = q[s];
        ex[s].v     = 64'd1;
        ex[s].idx   = 64'(s);
        ex[s].pc    = {32'd0, in_pc[k]};
        ex[s].instr = {32'd0, in_instr[k]};
        ex[s].misc  = misc(in_skip[k], in_tlb[k], in_tidx[k], in_cnt[k], in_rstat[k],
                           in_wen[k] && in_wdest[k] != 5'd0, {3'd0, in_wdest[k]});
        ex[s].csr   = {32'd0, in_csr[k]};
        ex[s].tmr   = timer;
        ex[s].wdata = {32'd0, in_wdata[k]};
        if (in_wen[k] && in_wdest[k] != 5'd0) mg[in_wdest[k]] = {32'd0, in_wdata[k]};
      end
      mcc = mcc + 64'(q.size());
      if (q.size() > 0) midle = 0;
      else if (midle < T) midle++;
      if (midle >= T) mhang = 1'b1;
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    for (int s = 0; s < 4; s++) begin
      chk($sformatf("valid%0d", s), {63'd0, o_v[s]}, ex[s].v);
      chk($sformatf("index%0d", s), {56'd0, o_idx[s]}, ex[s].idx);
      chk($sformatf("pc%0d", s), o_pc[s], ex[s].pc);
      chk($sformatf("instr%0d", s), {32'd0, o_instr[s]}, ex[s].instr);
      chk($sformatf("misc%0d", s), misc(o_skip[s], o_tlb[s], o_tidx[s], o_cnt[s], o_rstat[s],
                                        o_wen[s], o_wdest[s]), ex[s].misc);
      chk($sformatf("csr%0d", s), {32'd0, o_csr[s]}, ex[s].csr);
      chk($sformatf("timer%0d", s), o_timer[s], ex[s].tmr);
      chk($sformatf("wdata%0d", s), o_wdata[s], ex[s].wdata);
    end
    for (int r = 0; r < 32; r++) chk($sformatf("REG_%0d", r), REG[r], mg[r]);
    chk("commit_count", cc, mcc);
    chk("hang", {63'd0, hang}, {63'd0, mhang});
  endtask

  task automatic full_bundle(input logic [31:0] base, input logic rst);
    for (int k = 0; k < 4; k++) set_lane(k, base + 32'(4 * k), 1'($urandom_range(0, 1)),
                                         5'($urandom_range(0, 31)), $urandom);
    step(rst);
  endtask

  initial begin
    logic [31:0] base;
    idle_lanes();
    timer = '0;
    step(1'b1);
    step(1'b1);

    // Holes: lanes 1 and 3 only
    idle_lanes();
    set_lane(1, 32'h1c000004, 1'b0, 5'd0, 32'd0);
    set_lane(3, 32'h1c00000c, 1'b0, 5'd0, 32'd0);
    step(1'b0);
    chk("holes_pc0", o_pc[0], 64'h000000001c000004);
    chk("holes_pc1", o_pc[1], 64'h000000001c00000c);
    chk("holes_valid", {60'd0, o_v[3], o_v[2], o_v[1], o_v[0]}, 64'h3);
    chk("holes_idx1", {56'd0, o_idx[1]}, 64'd1);
    chk("holes_cc", cc, 64'd2);

    // Same-destination collision
    idle_lanes();
    set_lane(0, 32'h1c000010, 1'b1, 5'd5, 32'h11);
    set_lane(2, 32'h1c000018, 1'b1, 5'd5, 32'h22);
    step(1'b0);
    chk("collide_reg5", REG[5], 64'h22);

    // r0 and zero-extension
    idle_lanes();
    set_lane(0, 32'h1c000020, 1'b1, 5'd0, 32'hffffffff);
    set_lane(1, 32'h1c000024, 1'b1, 5'd4, 32'h80000000);
    step(1'b0);
    chk("r0_wen0", {63'd0, o_wen[0]}, 64'd0);
    chk("r0_reg0", REG[0], 64'd0);
    chk("sext_reg4", REG[4], 64'h0000000080000000);

    // Watchdog
    idle_lanes();
    step(1'b1);
    repeat (T - 1) step(1'b0);
    chk("wd_before", {63'd0, hang}, 64'd0);
    step(1'b0);
    chk("wd_set", {63'd0, hang}, 64'd1);
    set_lane(0, 32'h1c000030, 1'b0, 5'd0, 32'd0);
    step(1'b0);
    chk("wd_sticky", {63'd0, hang}, 64'd1);
    idle_lanes();
    step(1'b1);
    chk("wd_reset", {63'd0, hang}, 64'd0);

    // Reset arriving with a live bundle
    for (int i = 0; i < 3; i++) full_bundle(32'h1c001000 + 32'(16 * i), 1'b0);
    full_bundle(32'h1c002000, 1'b1);
    chk("rst_cc", cc, 64'd0);
    chk("rst_v0", {63'd0, o_v[0]}, 64'd0);
    chk("rst_pc3", o_pc[3], 64'd0);

    // Throughput: sustained full bundles
    base = 32'h1c010000;
    for (int i = 0; i < 100; i++) begin
      full_bundle(base, 1'b0);
      for (int s = 0; s < 4; s++) chk("thru_pc", o_pc[s], {32'd0, base + 32'(4 * s)});
      base = base + 32'd16;
    end
    chk("thru_cc", cc, 64'd400);

    // Random bundles with occasional long idle runs and resets
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        idle_lanes();
        repeat (T + 2) step(1'b0);
      end
      for (int k = 0; k < 4; k++) rnd_lane(k, ($urandom_range(0, 9) < 3) ? 1'b0 : 1'($urandom_range(0, 1)));
      step(($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
